// File: rtl/mvm_pkg.sv
// Shared definitions for the matrix-vector engine: default geometry,
// X-loader state encoding and derived element count.
package mvm_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ROWS   = 8;
  localparam int unsigned DEF_COLS   = 4;
  localparam int unsigned X_ELEMS    = DEF_ROWS * DEF_COLS;

  typedef enum logic [1:0] {
    XL_IDLE,
    XL_LOAD,
    XL_DONE
  } xl_state_e;

endpackage

// File: rtl/x_buffer.sv
// Column-major X operand store: one write port (index = col*ROWS + row),
// a combinational (row, col) read port and a synchronous clear.
module x_buffer
  import mvm_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned CNT_W  = $clog2(ROWS * COLS)
) (
  input  logic                    clk,
  input  logic                    clr_i,
  input  logic                    wr_en_i,
  input  logic [CNT_W-1:0]        wr_idx_i,
  input  logic [DATA_W-1:0]       wr_data_i,
  input  logic [1:0]              rd_col_i,
  input  logic [$clog2(ROWS)-1:0] rd_row_i,
  output logic [DATA_W-1:0]       rd_data_o
);

  localparam int unsigned NELEM = ROWS * COLS;

  logic [DATA_W-1:0] mem_q [NELEM];
  logic [CNT_W-1:0]  rd_idx;

  // Storage: clear wins over a coincident write.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int unsigned i = 0; i < NELEM; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Read port: column-major address decode, old data during a same-cycle write.
  always_comb begin
    rd_idx    = CNT_W'(rd_col_i) * CNT_W'(ROWS) + CNT_W'(rd_row_i);
    rd_data_o = mem_q[rd_idx];
  end

endmodule

// File: rtl/x_input_loader.sv
// X operand input loader: accepts ROWS*COLS streamed elements while the
// controller holds input_load_en, then signals xload_done and serves the
// stored matrix on a combinational read port.
// Optional build macro XLOAD_PARITY_EN adds in_parity / sticky par_err.
module x_input_loader
  import mvm_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned CNT_W  = $clog2(ROWS * COLS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    input_load_en,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    xload_done,
  input  logic [1:0]              rd_col,
  input  logic [$clog2(ROWS)-1:0] rd_row,
  output logic [DATA_W-1:0]       rd_data
`ifdef XLOAD_PARITY_EN
  ,
  input  logic                    in_parity,
  output logic                    par_err
`endif
);

  localparam int unsigned NELEM = ROWS * COLS;

  xl_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en;
  logic             last_beat;

  // State and element counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= XL_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and write-enable decode; abort wins the transition
  // but a coincident beat is still written.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en     = 1'b0;
    last_beat = (cnt_q == CNT_W'(NELEM - 1));
    case (state_q)
      XL_IDLE: begin
        if (input_load_en) begin
          state_d = XL_LOAD;
          cnt_d   = '0;
        end
      end
      XL_LOAD: begin
        if (in_valid) begin
          wr_en = 1'b1;
          cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
        end
        if (!input_load_en) begin
          state_d = XL_IDLE;
          cnt_d   = '0;
        end else if (in_valid && last_beat) begin
          state_d = XL_DONE;
        end
      end
      XL_DONE: begin
        if (!input_load_en) begin
          state_d = XL_IDLE;
        end
      end
      default: begin
        state_d = XL_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign in_ready   = (state_q == XL_LOAD);
  assign xload_done = (state_q == XL_DONE);

  x_buffer #(
    .DATA_W (DATA_W),
    .ROWS   (ROWS),
    .COLS   (COLS),
    .CNT_W  (CNT_W)
  ) u_x_buffer (
    .clk       (clk),
    .clr_i     (rst),
    .wr_en_i   (wr_en),
    .wr_idx_i  (cnt_q),
    .wr_data_i (in_data),
    .rd_col_i  (rd_col),
    .rd_row_i  (rd_row),
    .rd_data_o (rd_data)
  );

`ifdef XLOAD_PARITY_EN
  logic par_err_q, par_err_d;

  // Sticky parity error: cleared when a new load starts, set by any
  // accepted beat whose even-parity bit disagrees with the data.
  always_comb begin
    par_err_d = par_err_q;
    if ((state_q == XL_IDLE) && input_load_en) begin
      par_err_d = 1'b0;
    end else if (wr_en && (in_parity != (^in_data))) begin
      par_err_d = 1'b1;
    end
  end

  // Parity error flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_x_input_loader.sv
// Directed/randomized bench for x_input_loader. A plain array holds the
// expected matrix contents; handshake expectations come from beat counts.
module tb_x_input_loader;
  import mvm_pkg::*;

  localparam int unsigned ROWS = DEF_ROWS;
  localparam int unsigned COLS = DEF_COLS;
  localparam int unsigned N    = X_ELEMS;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       xload_done;
  logic [1:0] rd_col;
  logic [2:0] rd_row;
  logic [7:0] rd_data;
`ifdef XLOAD_PARITY_EN
  logic       in_parity;
  logic       par_err;
  logic       corrupt_next = 1'b0;
`endif

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned failed = 0;
  logic [7:0]  model [N];

  always #5 clk = ~clk;

  x_input_loader #(
    .DATA_W (8),
    .ROWS   (ROWS),
    .COLS   (COLS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .input_load_en (en),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .xload_done    (xload_done),
    .rd_col        (rd_col),
    .rd_row        (rd_row),
    .rd_data       (rd_data)
`ifdef XLOAD_PARITY_EN
    ,
    .in_parity     (in_parity),
    .par_err       (par_err)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
`ifdef XLOAD_PARITY_EN
    in_parity    = (^d) ^ corrupt_next;
    corrupt_next = 1'b0;
`endif
    step();
  endtask

  task automatic rd_chk(input string tag, input int unsigned c, input int unsigned r,
                        input logic [7:0] exp);
    rd_col = 2'(c);
    rd_row = 3'(r);
    #1;
    chk(tag, rd_data, exp);
  endtask

  task automatic check_all(input string tag);
    for (int unsigned c = 0; c < COLS; c++) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        rd_chk(tag, c, r, model[c * ROWS + r]);
      end
    end
  endtask

  initial begin
    int unsigned acc;
    int unsigned cyc;
    logic        v;
    logic [7:0]  d;

    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = '0;
    rd_col = '0; rd_row = '0;
`ifdef XLOAD_PARITY_EN
    in_parity = 1'b0;
`endif
    for (int unsigned i = 0; i < N; i++) model[i] = '0;

    // Reset state
    repeat (2) step();
    chk("rst_ready", in_ready, 0);
    chk("rst_done", xload_done, 0);
    rst = 1'b0;
    step();
    check_all("rst_buf");
`ifdef XLOAD_PARITY_EN
    chk("rst_par", par_err, 0);
`endif

    // Full load of 1..32 at one beat per cycle
    en = 1'b1;
    step();
    chk("t1_ready_entry", in_ready, 1);
    chk("t1_done_entry", xload_done, 0);
    for (int unsigned k = 0; k < N; k++) begin
`ifdef XLOAD_PARITY_EN
      if (k == 6) corrupt_next = 1'b1;
`endif
      beat(1'b1, 8'(k + 1));
      model[k] = 8'(k + 1);
      acc = k + 1;
      chk("t1_ready", in_ready, acc < N);
      chk("t1_done", xload_done, acc == N);
`ifdef XLOAD_PARITY_EN
      chk("t1_par", par_err, k >= 6);
`endif
    end
    in_valid = 1'b0;
    rd_chk("t1_first_elem", 0, 0, 8'd1);
    rd_chk("t1_col2_row5", 2, 5, 8'd22);
    check_all("t1_buf");

    // Beats in DONE are ignored
    for (int unsigned k = 0; k < 5; k++) begin
      beat(1'b1, 8'hFF);
      chk("done_hold", xload_done, 1);
      chk("done_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    check_all("done_buf");
    en = 1'b0;
    step();
    chk("done_exit", xload_done, 0);
    chk("done_exit_ready", in_ready, 0);
    rd_chk("idle_hold", 3, 7, 8'd32);
`ifdef XLOAD_PARITY_EN
    chk("par_sticky_idle", par_err, 1);
`endif

    // Gapped stream with random data; same-cycle write/read check
    en = 1'b1;
    step();
    chk("t2_ready_entry", in_ready, 1);
`ifdef XLOAD_PARITY_EN
    chk("par_cleared", par_err, 0);
`endif
    acc = 0;
    cyc = 0;
    while (acc < N && cyc < 400) begin
      v = ((cyc % 2) == 0);
      d = 8'($urandom);
      rd_col   = 2'(acc / ROWS);
      rd_row   = 3'(acc % ROWS);
      in_valid = v;
      in_data  = d;
      #1;
      chk("t2_rd_old", rd_data, model[acc]);
      beat(v, d);
      if (v) begin
        model[acc] = d;
        chk("t2_rd_new", rd_data, d);
        acc++;
      end
      chk("t2_ready", in_ready, acc < N);
      chk("t2_done", xload_done, acc == N);
      cyc++;
    end
    chk("t2_bound", acc, N);
    in_valid = 1'b0;
    check_all("t2_order");
    en = 1'b0;
    step();
    chk("t2_exit", xload_done, 0);

    // Abort after 10 beats, abort coincides with an 11th beat
    en = 1'b1;
    step();
    for (int unsigned k = 0; k < 10; k++) begin
      d = 8'($urandom);
      beat(1'b1, d);
      model[k] = d;
      chk("ab_ready", in_ready, 1);
      chk("ab_done", xload_done, 0);
    end
    en = 1'b0;
    d = 8'($urandom);
    beat(1'b1, d);
    model[10] = d;
    chk("ab_idle_ready", in_ready, 0);
    chk("ab_idle_done", xload_done, 0);
    in_valid = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      step();
      chk("ab_done_low", xload_done, 0);
    end
    check_all("ab_partial");

    // Re-enable restarts at index 0
    en = 1'b1;
    step();
    for (int unsigned k = 0; k < N; k++) begin
      beat(1'b1, 8'(100 + k));
      model[k] = 8'(100 + k);
    end
    in_valid = 1'b0;
    chk("reload_done", xload_done, 1);
    rd_chk("reload_00", 0, 0, 8'd100);
    check_all("reload_buf");
    en = 1'b0;
    step();

    // Reset mid-load at beat 20
    en = 1'b1;
    step();
    for (int unsigned k = 0; k < 20; k++) begin
      beat(1'b1, 8'(200 + k));
      model[k] = 8'(200 + k);
    end
    rst = 1'b1;
    beat(1'b1, 8'hAA);
    in_valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) model[i] = '0;
    chk("mrst_ready", in_ready, 0);
    chk("mrst_done", xload_done, 0);
    check_all("mrst_buf");
    rst = 1'b0;
    step();
    chk("mrst_reentry", in_ready, 1);
    beat(1'b1, 8'h5A);
    model[0] = 8'h5A;
    in_valid = 1'b0;
    rd_chk("mrst_cnt0", 0, 0, 8'h5A);
    rd_chk("mrst_next", 0, 1, 8'h00);
`ifdef XLOAD_PARITY_EN
    chk("mrst_par", par_err, 0);
`endif
    en = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
